// File: rtl/game_timer_if.sv
// Control and display bundle between the access controller and the BCD countdown timer.
// The controller side (master) drives run/reload requests; the timer (slave) returns digits.
interface game_timer_if;
  logic       timerEnable;
  logic       reconfig;
  logic [3:0] cfgMin;
  logic [3:0] minOnes;
  logic [3:0] secTens;
  logic [3:0] secOnes;
  logic       finalTimeout;
  logic       lowTime;
  logic       secTick;

  modport master (
    output timerEnable, reconfig, cfgMin,
    input  minOnes, secTens, secOnes, finalTimeout, lowTime, secTick
  );

  modport slave (
    input  timerEnable, reconfig, cfgMin,
    output minOnes, secTens, secOnes, finalTimeout, lowTime, secTick
  );
endinterface

// File: rtl/game_timer.sv
// M:SS BCD countdown timer for a game round; pauses when timerEnable drops and
// pulses finalTimeout on the edge that first shows 0:00.
module game_timer #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter logic [3:0]  DEFAULT_MIN   = 4'd1,
  parameter logic [5:0]  LOW_SEC       = 6'd10
) (
  input logic         clk,
  input logic         rst,
  game_timer_if.slave bus
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PresLast = PW'(TICKS_PER_SEC - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          final_q, final_d;
  logic          low_q, low_d;
  logic          tick_q, tick_d;

  logic [3:0]    cfg_clamped;
  logic [9:0]    remaining;
  logic          last_sec;

  always_comb begin
    cfg_clamped = bus.cfgMin;
    if (bus.cfgMin > 4'd9) begin
      cfg_clamped = 4'd9;
    end else if (bus.cfgMin == 4'd0) begin
      cfg_clamped = 4'd1;
    end
  end

  always_comb begin
    remaining = 10'(min_q) * 10'd60 + 10'(tens_q) * 10'd10 + 10'(ones_q);
    low_d     = (state_q == ST_RUN) && (remaining <= 10'(LOW_SEC));
    // 0:01 (or an already-zero display) means this tick ends the round
    last_sec  = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q <= 4'd1);
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    final_d = 1'b0;
    tick_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.reconfig) begin
          min_d  = cfg_clamped;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (bus.timerEnable) begin
          presc_d = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.timerEnable) begin
          if (presc_q == PresLast) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
              tens_d = tens_q - 4'd1;
              ones_d = 4'd9;
            end else if (min_q != 4'd0) begin
              min_d  = min_q - 4'd1;
              tens_d = 4'd5;
              ones_d = 4'd9;
            end
            if (last_sec) begin
              final_d = 1'b1;
              state_d = ST_EXPIRED;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      ST_EXPIRED: begin
        if (bus.reconfig) begin
          min_d   = cfg_clamped;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      min_q   <= DEFAULT_MIN;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      final_q <= 1'b0;
      low_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      final_q <= final_d;
      low_q   <= low_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.minOnes      = min_q;
  assign bus.secTens      = tens_q;
  assign bus.secOnes      = ones_q;
  assign bus.finalTimeout = final_q;
  assign bus.lowTime      = low_q;
  assign bus.secTick      = tick_q;

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: stimulus queues the expected display for every
// second tick; a negedge monitor pops and compares whenever secTick is presented.
module tb_game_timer;

  localparam int unsigned Ticks  = 4;
  localparam int unsigned LowSec = 10;

  typedef struct {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       fin;
    logic       low;
  } exp_t;

  logic clk;
  logic rst;
  game_timer_if bus ();

  game_timer #(
    .TICKS_PER_SEC(Ticks),
    .DEFAULT_MIN  (4'd1),
    .LOW_SEC      (6'd10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sec     = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [11:0] digits();
    return {bus.minOnes, bus.secTens, bus.secOnes};
  endfunction

  // Expected display is derived from a plain seconds count, not from digit borrow rules.
  task automatic run_ticks(input int n);
    int prev;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      prev  = sec;
      sec   = sec - 1;
      e.m   = 4'(sec / 60);
      e.t   = 4'((sec % 60) / 10);
      e.o   = 4'(sec % 10);
      e.fin = (sec == 0);
      e.low = (prev <= LowSec);
      exp_q.push_back(e);
      for (int s = 1; s <= 4; s++) begin
        step();
        if (s == 1) check("low_time", {31'd0, bus.lowTime}, {31'd0, prev <= LowSec});
        if (s < 4) check("no_early_tick", {30'd0, bus.secTick, bus.finalTimeout}, 32'd0);
        else       check("tick_due", {31'd0, bus.secTick}, 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.secTick) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick: got display %0h with no tick expected at %0t",
                 {bus.minOnes, bus.secTens, bus.secOnes}, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("tick_value",
              {18'd0, bus.minOnes, bus.secTens, bus.secOnes, bus.finalTimeout, bus.lowTime},
              {18'd0, mon_e.m, mon_e.t, mon_e.o, mon_e.fin, mon_e.low});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b0;
    bus.timerEnable = 1'b0;
    bus.reconfig    = 1'b0;
    bus.cfgMin      = 4'd0;
    #7;
    check("reset_digits", {20'd0, digits()}, 32'h100);
    check("reset_flags", {29'd0, bus.finalTimeout, bus.lowTime, bus.secTick}, 32'd0);

    @(negedge clk);
    rst          = 1'b1;
    bus.reconfig = 1'b1;
    bus.cfgMin   = 4'hC;
    step();
    check("clamp_high", {20'd0, digits()}, 32'h900);
    bus.cfgMin = 4'd0;
    step();
    check("clamp_zero", {20'd0, digits()}, 32'h100);
    // reload and run in the same cycle: reload wins, RUN starts one cycle later
    bus.cfgMin      = 4'd2;
    bus.timerEnable = 1'b1;
    step();
    check("load_priority", {20'd0, digits()}, 32'h200);
    bus.reconfig = 1'b0;
    step();
    sec = 120;
    run_ticks(1);

    step();
    step();
    bus.timerEnable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("pause_no_tick", {30'd0, bus.secTick, bus.finalTimeout}, 32'd0);
      check("pause_hold", {20'd0, digits()}, 32'h159);
    end
    bus.timerEnable = 1'b1;
    sec = 118;
    mon_e.m = 4'd1; mon_e.t = 4'd5; mon_e.o = 4'd8; mon_e.fin = 1'b0; mon_e.low = 1'b0;
    exp_q.push_back(mon_e);
    step();
    check("resume_partial", {31'd0, bus.secTick}, 32'd0);
    step();
    check("resume_tick", {31'd0, bus.secTick}, 32'd1);

    run_ticks(73);
    check("at_045", {20'd0, digits()}, 32'h045);
    step();
    step();
    #2;
    rst             = 1'b0;
    bus.timerEnable = 1'b0;
    #1;
    check("async_reset_digits", {20'd0, digits()}, 32'h100);
    check("async_reset_flags", {29'd0, bus.finalTimeout, bus.lowTime, bus.secTick}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    bus.timerEnable = 1'b1;
    step();
    sec = 60;
    run_ticks(60);
    step();
    check("final_one_cycle", {30'd0, bus.finalTimeout, bus.lowTime}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("expired_hold", {19'd0, digits(), bus.secTick}, 32'd0);
    end

    bus.reconfig = 1'b1;
    bus.cfgMin   = 4'd3;
    step();
    check("expired_reload", {20'd0, digits()}, 32'h300);
    bus.reconfig = 1'b0;
    step();
    sec = 180;
    run_ticks(1);

    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
